// File: rtl/i2c_pkg.sv
// Shared types for the I2C target and the master's bench: FSM states, bit counter, byte type.
package i2c_pkg;

  localparam int BIT_CNT_W = 3;

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;
  typedef logic [7:0]           data_t;

  localparam bit_cnt_t BIT_CNT_MSB = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_IGNORE
  } i2c_state_t;

endpackage

// File: rtl/i2c_slave_if.sv
// Bus pins and user-side byte handshake of the I2C target.
interface i2c_slave_if;
  import i2c_pkg::*;

  logic  scl_in;
  logic  sda_in;
  logic  sda_oe;
  data_t rx_data;
  logic  rx_valid;
  data_t tx_data;
  logic  tx_req;
  logic  busy;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, busy
  );

  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, busy
  );
endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-stage synchroniser with rise/fall strobes; flops preset high to match an idle bus.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              q_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '1;
      q_d    <= 1'b1;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      q_d    <= sync_r[STAGES-1];
    end
  end

  assign q    = sync_r[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, fixed 7-bit address, byte delivery on write, byte request on read.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h58,
  parameter int         SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         reset,
  i2c_slave_if.slave  bus
);

  // state       | meaning
  // ST_IDLE     | bus idle, waiting for START
  // ST_ADDR     | shifting address + R/W
  // ST_ADDR_ACK | driving address ACK
  // ST_RX       | shifting a write byte in
  // ST_RX_ACK   | driving data ACK
  // ST_TX       | shifting a read byte out
  // ST_TX_ACK   | sampling master ACK/NACK
  // ST_IGNORE   | not addressed, waiting for START/STOP

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .reset(reset), .d(bus.scl_in), .q(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .reset(reset), .d(bus.sda_in), .q(sda), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = scl & sda_fall;
  assign stop_det  = scl & sda_rise;

  i2c_state_t state, state_nxt;
  data_t      shreg, shreg_nxt;
  bit_cnt_t   cnt, cnt_nxt;
  data_t      rx_data_r, rx_data_nxt;
  logic       sda_oe_r, sda_oe_nxt;
  logic       rx_valid_r, rx_valid_nxt;
  logic       tx_req_r, tx_req_nxt, tx_req_d;
  logic       busy_r, busy_nxt;

  data_t shift_in;
  logic  last_bit, addr_hit;
  assign shift_in = {shreg[6:0], sda};
  assign last_bit = (cnt == '0);
  assign addr_hit = (shreg[6:0] == ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = ST_ADDR;
    end else if (stop_det) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR:     if (scl_rise && last_bit) state_nxt = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
        // sda_oe doubles as the ACK phase flag: the second fall ends the ACK bit
        ST_ADDR_ACK: if (scl_fall && sda_oe_r) state_nxt = shreg[0] ? ST_TX : ST_RX;
        ST_RX:       if (scl_rise && last_bit) state_nxt = ST_RX_ACK;
        ST_RX_ACK:   if (scl_fall && sda_oe_r) state_nxt = ST_RX;
        ST_TX:       if (scl_fall && last_bit) state_nxt = ST_TX_ACK;
        ST_TX_ACK: begin
          if (scl_rise && sda) state_nxt = ST_IGNORE;
          else if (scl_fall)   state_nxt = ST_TX;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    shreg_nxt    = shreg;
    cnt_nxt      = cnt;
    rx_data_nxt  = rx_data_r;
    sda_oe_nxt   = sda_oe_r;
    rx_valid_nxt = 1'b0;
    tx_req_nxt   = 1'b0;
    busy_nxt     = busy_r;
    if (start_det) begin
      cnt_nxt    = BIT_CNT_MSB;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (stop_det) begin
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shreg_nxt = shift_in;
            cnt_nxt   = cnt - bit_cnt_t'(1);
            if (last_bit && addr_hit) busy_nxt = 1'b1;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt = ~sda_oe_r;
            if (sda_oe_r && shreg[0]) tx_req_nxt = 1'b1;
          end
        end
        ST_RX: begin
          if (scl_rise) begin
            shreg_nxt = shift_in;
            cnt_nxt   = cnt - bit_cnt_t'(1);
            if (last_bit) begin
              rx_data_nxt  = shift_in;
              rx_valid_nxt = 1'b1;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) sda_oe_nxt = ~sda_oe_r;
        end
        ST_TX: begin
          // bit 7 goes out as soon as the requested byte is captured
          if (tx_req_d) begin
            shreg_nxt  = bus.tx_data;
            sda_oe_nxt = ~bus.tx_data[7];
          end else if (scl_fall) begin
            cnt_nxt = cnt - bit_cnt_t'(1);
            if (last_bit) begin
              sda_oe_nxt = 1'b0;
            end else begin
              shreg_nxt  = {shreg[6:0], 1'b0};
              sda_oe_nxt = ~shreg[6];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_fall) tx_req_nxt = 1'b1;
        end
        default: sda_oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      cnt        <= '0;
      rx_data_r  <= '0;
      sda_oe_r   <= 1'b0;
      rx_valid_r <= 1'b0;
      tx_req_r   <= 1'b0;
      tx_req_d   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      shreg      <= shreg_nxt;
      cnt        <= cnt_nxt;
      rx_data_r  <= rx_data_nxt;
      sda_oe_r   <= sda_oe_nxt;
      rx_valid_r <= rx_valid_nxt;
      tx_req_r   <= tx_req_nxt;
      tx_req_d   <= tx_req_r;
      busy_r     <= busy_nxt;
    end
  end

  assign bus.sda_oe   = sda_oe_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.tx_req   = tx_req_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged master with wired-AND SDA and a byte source for reads.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic [7:0] tx_byte = 8'h00;

  always #5 clk = ~clk;

  i2c_slave_if bus();
  assign bus.scl_in  = m_scl;
  assign bus.sda_in  = m_sda & ~bus.sda_oe;
  assign bus.tx_data = tx_byte;

  i2c_slave #(.ADDR(7'h58), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_log[$];
  logic [7:0] tx_list[4];
  int tx_idx = 0, tx_reqs = 0, oe_cnt = 0, busy_cnt = 0, both_cnt = 0, addr_entries = 0;
  i2c_state_t prev_state = ST_IDLE;

  always @(negedge clk) begin
    if (bus.rx_valid) rx_log.push_back(bus.rx_data);
    if (bus.tx_req) begin
      tx_reqs++;
      tx_byte <= tx_list[tx_idx % 4];
      tx_idx  <= tx_idx + 1;
    end
    if (bus.sda_oe) oe_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.rx_valid && bus.tx_req) both_cnt++;
    if (dut.state == ST_ADDR && prev_state != ST_ADDR) addr_entries++;
    prev_state = dut.state;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic smp);
    m_sda = b;    clks(Q);
    m_scl = 1'b1; clks(Q);
    smp = bus.sda_in; clks(Q);
    m_scl = 1'b0; clks(Q);
  endtask

  task automatic start_cond();
    m_sda = 1'b1; clks(Q);
    m_scl = 1'b1; clks(Q);
    m_sda = 1'b0; clks(Q);
    m_scl = 1'b0; clks(Q);
  endtask

  task automatic stop_cond();
    m_sda = 1'b0; clks(Q);
    m_scl = 1'b1; clks(Q);
    m_sda = 1'b1; clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
    bus_bit(mack, s);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda_oe"},   32'(bus.sda_oe),   32'h0);
    check({tag, "_rx_data"},  32'(bus.rx_data),  32'h0);
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'h0);
    check({tag, "_tx_req"},   32'(bus.tx_req),   32'h0);
    check({tag, "_busy"},     32'(bus.busy),     32'h0);
    check({tag, "_state"},    32'(dut.state),    32'(ST_IDLE));
  endtask

  typedef struct {
    logic [7:0] addr_b;
    logic [7:0] data_b;
    logic       exp_nack;
  } wvec_t;

  wvec_t vecs[7];

  initial begin
    logic a0, a1, a2;
    logic [7:0] rb0, rb1;
    int n0, o0, b0, t0, e0;

    vecs[0] = '{8'hB0, 8'h12, 1'b0};
    vecs[1] = '{8'hB0, 8'h34, 1'b0};
    vecs[2] = '{8'h42, 8'h55, 1'b1};
    vecs[3] = '{8'hB0, 8'hFF, 1'b0};
    vecs[4] = '{8'hB0, 8'h00, 1'b0};
    vecs[5] = '{8'hB2, 8'h81, 1'b1};
    vecs[6] = '{8'h30, 8'h5A, 1'b1};
    tx_list = '{8'hA5, 8'h3C, 8'h5E, 8'h00};

    clks(5);
    check_reset_outputs("rst");
    reset = 1'b0;
    clks(5);

    // two-byte write
    n0 = rx_log.size();
    start_cond();
    write_byte(8'hB0, a0);
    check("wr_busy_mid", 32'(bus.busy), 32'h1);
    write_byte(8'h12, a1);
    write_byte(8'h34, a2);
    stop_cond();
    check("wr_ack_addr", 32'(a0), 32'h0);
    check("wr_ack_d0",   32'(a1), 32'h0);
    check("wr_ack_d1",   32'(a2), 32'h0);
    check("wr_rx_count", 32'(rx_log.size() - n0), 32'd2);
    if (rx_log.size() >= n0 + 2) begin
      check("wr_rx0", 32'(rx_log[n0]),     32'h12);
      check("wr_rx1", 32'(rx_log[n0 + 1]), 32'h34);
    end
    check("wr_busy_end", 32'(bus.busy), 32'h0);

    // single-byte write table, including address mismatches
    for (int i = 0; i < 7; i++) begin
      n0 = rx_log.size();
      o0 = oe_cnt;
      b0 = busy_cnt;
      start_cond();
      write_byte(vecs[i].addr_b, a1);
      check($sformatf("v%0d_busy_mid", i), 32'(bus.busy), 32'(!vecs[i].exp_nack));
      write_byte(vecs[i].data_b, a2);
      stop_cond();
      check($sformatf("v%0d_ack_addr", i), 32'(a1), 32'(vecs[i].exp_nack));
      check($sformatf("v%0d_ack_data", i), 32'(a2), 32'(vecs[i].exp_nack));
      check($sformatf("v%0d_rx_count", i), 32'(rx_log.size() - n0), vecs[i].exp_nack ? 32'd0 : 32'd1);
      if (!vecs[i].exp_nack && rx_log.size() > n0)
        check($sformatf("v%0d_rx_data", i), 32'(rx_log[n0]), 32'(vecs[i].data_b));
      check($sformatf("v%0d_oe_seen", i),   32'(oe_cnt != o0),   32'(!vecs[i].exp_nack));
      check($sformatf("v%0d_busy_seen", i), 32'(busy_cnt != b0), 32'(!vecs[i].exp_nack));
      check($sformatf("v%0d_busy_end", i),  32'(bus.busy), 32'h0);
    end

    // read two bytes: ACK then NACK
    t0 = tx_reqs;
    start_cond();
    write_byte(8'hB1, a0);
    read_byte(1'b0, rb0);
    read_byte(1'b1, rb1);
    check("rd_ack_addr", 32'(a0),  32'h0);
    check("rd_byte0",    32'(rb0), 32'hA5);
    check("rd_byte1",    32'(rb1), 32'h3C);
    check("rd_oe_nack",  32'(bus.sda_oe), 32'h0);
    check("rd_state_nack", 32'(dut.state), 32'(ST_IGNORE));
    stop_cond();
    check("rd_tx_reqs", 32'(tx_reqs - t0), 32'd2);
    check("rd_busy_end", 32'(bus.busy), 32'h0);

    // write, repeated START, single-byte read
    t0 = tx_reqs;
    e0 = addr_entries;
    start_cond();
    write_byte(8'hB0, a0);
    write_byte(8'h07, a1);
    start_cond();
    write_byte(8'hB1, a2);
    read_byte(1'b1, rb0);
    stop_cond();
    check("rs_ack_w",    32'(a0), 32'h0);
    check("rs_ack_d",    32'(a1), 32'h0);
    check("rs_ack_r",    32'(a2), 32'h0);
    check("rs_rx_data",  32'(bus.rx_data), 32'h07);
    check("rs_tx_reqs",  32'(tx_reqs - t0), 32'd1);
    check("rs_rd_byte",  32'(rb0), 32'h5E);
    check("rs_addr_cnt", 32'(addr_entries - e0), 32'd2);

    // STOP after four data bits, then a normal write
    n0 = rx_log.size();
    start_cond();
    write_byte(8'hB0, a0);
    for (int i = 0; i < 4; i++) bus_bit(i[0], a1);
    stop_cond();
    check("sm_ack_addr", 32'(a0), 32'h0);
    check("sm_no_rx",    32'(rx_log.size() - n0), 32'd0);
    check("sm_state",    32'(dut.state), 32'(ST_IDLE));
    check("sm_busy",     32'(bus.busy), 32'h0);
    start_cond();
    write_byte(8'hB0, a0);
    write_byte(8'h99, a1);
    stop_cond();
    check("sm_next_ack",  32'(a0), 32'h0);
    check("sm_next_dack", 32'(a1), 32'h0);
    check("sm_next_rx",   32'(bus.rx_data), 32'h99);

    check("no_rx_tx_overlap", 32'(both_cnt), 32'd0);

    // async reset while driving the address ACK
    start_cond();
    for (int i = 7; i >= 0; i--) bus_bit(i == 7 || i == 5 || i == 4, a0);
    clks(Q);
    check("ar_oe_before", 32'(bus.sda_oe), 32'h1);
    check("ar_state_before", 32'(dut.state), 32'(ST_ADDR_ACK));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("ar");
    m_sda = 1'b1;
    m_scl = 1'b1;
    clks(4);
    reset = 1'b0;
    clks(4);
    check("ar_idle_after", 32'(dut.state), 32'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
